spi_arbiter: RTL and testbench

Round-robin arbiter that shares the single SPI master among three requesters: command configuration, calibration fetch and trigger-level refresh. Each SPI master transaction drives the AFE gain DACs, the trigger-level DAC or the calibration EEPROM. The arbiter latches the winner's slave select and 16-bit word, then issues a one-cycle `wrt_SPI`. It holds the SPI master inputs stable until `SPI_done`, returns read data with a one-hot done pulse, and enforces an inter-transaction gap and a completion timeout.

---
 rtl/spi_arbiter_if.sv | 27 ++
 rtl/spi_arbiter.sv | 154 +++++++++++++++
 tb/tb_spi_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals for the SPI arbiter.
// The arbiter takes the slave view; the requesters and SPI master drive the master view.
interface spi_arbiter_if;
   logic [2:0]  req;
   logic [8:0]  req_ss;
   logic [47:0] req_data;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic        err;
   logic [15:0] rdata;
   logic        busy;
   logic        wrt_SPI;
   logic [2:0]  ss;
   logic [15:0] SPI_data;
   logic        SPI_done;
   logic [15:0] SPI_rdata;

   modport slave (
      input  req, req_ss, req_data, SPI_done, SPI_rdata,
      output gnt, done, err, rdata, busy, wrt_SPI, ss, SPI_data
   );

   modport master (
      output req, req_ss, req_data, SPI_done, SPI_rdata,
      input  gnt, done, err, rdata, busy, wrt_SPI, ss, SPI_data
   );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among three requesters, with
// latched command word, completion timeout and a post-response idle gap.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's ss/word
// ISSUE | one-cycle wrt_SPI pulse to the SPI master; timeout counter cleared
// BUSY  | waiting for SPI_done or the timeout
// RESP  | one-cycle done pulse to the winner with rdata/err
// GAP   | GAP idle cycles before arbitrating again
module spi_arbiter #(
   parameter int GAP     = 2,
   parameter int TIMEOUT = 1024
) (
   input logic          clk,
   input logic          rst,
   spi_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_BUSY  = 3'd2,
      S_RESP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX  = '1;
   localparam logic [GW-1:0] G_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic [2:0]    ss_q, ss_d;
   logic [15:0]   data_q, data_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;

   logic [1:0]    p0, p1, p2, win;
   logic [2:0]    win_ss;
   logic [15:0]   win_data;
   logic [2:0]    owner;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search order starts just after the last winner.
   always_comb begin
      p0 = next_idx(last_q);
      p1 = next_idx(p0);
      p2 = next_idx(p1);
      win = p2;
      if (bus.req[p0])      win = p0;
      else if (bus.req[p1]) win = p1;
      win_ss   = bus.req_ss[2:0];
      win_data = bus.req_data[15:0];
      case (win)
         2'd1: begin
            win_ss   = bus.req_ss[5:3];
            win_data = bus.req_data[31:16];
         end
         2'd2: begin
            win_ss   = bus.req_ss[8:6];
            win_data = bus.req_data[47:32];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= 2'd2;
         ss_q    <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         ss_q    <= ss_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      ss_d    = ss_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               last_d  = win;
               ss_d    = win_ss;
               data_d  = win_data;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tcnt_d  = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (tcnt_q != T_MAX) tcnt_d = tcnt_q + 1'b1;
            // A completion in the timeout cycle still counts as success.
            if (bus.SPI_done) begin
               rdata_d = bus.SPI_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (tcnt_q == T_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            gcnt_d  = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gcnt_q == G_LAST) state_d = S_IDLE;
            else                  gcnt_d  = gcnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign owner = 3'b001 << last_q;

   assign bus.gnt      = (state_q == S_ISSUE || state_q == S_BUSY || state_q == S_RESP) ? owner : 3'b000;
   assign bus.done     = (state_q == S_RESP) ? owner : 3'b000;
   assign bus.wrt_SPI  = (state_q == S_ISSUE);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.ss       = ss_q;
   assign bus.SPI_data = data_q;
   assign bus.rdata    = rdata_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: a long-timeout instance with an SPI master
// model, and a short-timeout GAP=0 instance driven by hand for timeout cases.
module tb_spi_arbiter;

   typedef struct {
      int          idx;
      logic [2:0]  ss;
      logic [15:0] data;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rst_to;
   int   cyc = 0;
   int   total = 0, passed = 0;

   spi_arbiter_if bus();
   spi_arbiter_if bus2();

   spi_arbiter #(.GAP(2), .TIMEOUT(1024)) dut (.clk(clk), .rst(rst), .bus(bus));
   spi_arbiter #(.GAP(0), .TIMEOUT(16))   dut_to (.clk(clk), .rst(rst_to), .bus(bus2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t exp_q[$];
   exp_t exp2_q[$];
   int   wrt_cyc[$];
   int   ndone = 0, ndone2 = 0;
   int   wrt2_cyc = 0, done2_cyc = 0;
   exp_t e1, e2;

   // SPI master model for the main instance
   int          model_lat = 1;
   bit          use_fixed = 0;
   logic [15:0] fixed_rd = '0;
   bit          mact = 0;
   int          mcnt = 0;
   bit [2:0]    pend = '0;
   bit [2:0]    pend2 = '0;

   function automatic logic [2:0] onehot(input int idx);
      logic [2:0] v;
      v = 3'b001;
      return v << idx;
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.wrt_SPI) begin
            wrt_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) $display("FAIL unexpected_wrt: got gnt=%b ss=%0d data=%h, required no issue", bus.gnt, bus.ss, bus.SPI_data);
            else begin
               e1 = exp_q[0];
               if ({bus.gnt, bus.ss, bus.SPI_data} !== {onehot(e1.idx), e1.ss, e1.data})
                  $display("FAIL issue: got gnt=%b ss=%0d data=%h, required gnt=%b ss=%0d data=%h",
                           bus.gnt, bus.ss, bus.SPI_data, onehot(e1.idx), e1.ss, e1.data);
               else passed++;
            end
         end
         if (bus.done !== 3'b000) begin
            ndone++;
            total++;
            if (exp_q.size() == 0) $display("FAIL unexpected_done: got done=%b, required none", bus.done);
            else begin
               e1 = exp_q.pop_front();
               if ({bus.done, bus.rdata, bus.err} !== {onehot(e1.idx), e1.rdata, e1.err})
                  $display("FAIL done_resp: got done=%b rdata=%h err=%b, required done=%b rdata=%h err=%b",
                           bus.done, bus.rdata, bus.err, onehot(e1.idx), e1.rdata, e1.err);
               else passed++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_to === 1'b0) begin
         if (bus2.wrt_SPI) begin
            wrt2_cyc = cyc;
            total++;
            if (exp2_q.size() == 0) $display("FAIL unexpected_wrt2: got ss=%0d, required no issue", bus2.ss);
            else begin
               e2 = exp2_q[0];
               if ({bus2.gnt, bus2.ss, bus2.SPI_data} !== {onehot(e2.idx), e2.ss, e2.data})
                  $display("FAIL issue2: got gnt=%b ss=%0d data=%h, required gnt=%b ss=%0d data=%h",
                           bus2.gnt, bus2.ss, bus2.SPI_data, onehot(e2.idx), e2.ss, e2.data);
               else passed++;
            end
         end
         if (bus2.done !== 3'b000) begin
            ndone2++;
            done2_cyc = cyc;
            total++;
            if (exp2_q.size() == 0) $display("FAIL unexpected_done2: got done=%b, required none", bus2.done);
            else begin
               e2 = exp2_q.pop_front();
               if ({bus2.done, bus2.rdata, bus2.err} !== {onehot(e2.idx), e2.rdata, e2.err})
                  $display("FAIL done_resp2: got done=%b rdata=%h err=%b, required done=%b rdata=%h err=%b",
                           bus2.done, bus2.rdata, bus2.err, onehot(e2.idx), e2.rdata, e2.err);
               else passed++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mact = 0;
         bus.SPI_done = 1'b0;
      end else begin
         bus.SPI_done = 1'b0;
         if (bus.wrt_SPI) begin
            mact = 1;
            mcnt = model_lat;
         end else if (mact) begin
            mcnt--;
            if (mcnt <= 0) begin
               bus.SPI_done  = 1'b1;
               bus.SPI_rdata = use_fixed ? fixed_rd : (bus.SPI_data ^ 16'h5A5A);
               mact = 0;
            end
         end
      end
   end

   // Requesters drop their req in the cycle after seeing their done.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst === 1'b1) pend[i] = 1'b0;
         else begin
            if (pend[i]) begin bus.req[i] = 1'b0; pend[i] = 1'b0; end
            if (bus.done[i]) pend[i] = 1'b1;
         end
         if (rst_to === 1'b1) pend2[i] = 1'b0;
         else begin
            if (pend2[i]) begin bus2.req[i] = 1'b0; pend2[i] = 1'b0; end
            if (bus2.done[i]) pend2[i] = 1'b1;
         end
      end
   end

   task automatic wait_done(input bit second, input int target, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if ((second ? ndone2 : ndone) >= target) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rst_to = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.gnt, bus.done, bus.busy, bus.wrt_SPI} !== 8'h00)
         $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b wrt=%b, required all 0", bus.gnt, bus.done, bus.busy, bus.wrt_SPI);
      else passed++;
      total++;
      if ({bus.ss, bus.SPI_data, bus.rdata, bus.err} !== 36'h0)
         $display("FAIL reset_data: got ss=%0d data=%h rdata=%h err=%b, required 0", bus.ss, bus.SPI_data, bus.rdata, bus.err);
      else passed++;
      total++;
      if ({bus2.gnt, bus2.done, bus2.busy, bus2.wrt_SPI, bus2.ss, bus2.SPI_data, bus2.rdata, bus2.err} !== 44'h0)
         $display("FAIL reset_to: got gnt=%b busy=%b ss=%0d rdata=%h, required 0", bus2.gnt, bus2.busy, bus2.ss, bus2.rdata);
      else passed++;
      rst = 1'b0;
      rst_to = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bit ok;
      exp_q.push_back('{0, 3'd4, 16'h0905, 16'h00A7, 1'b0});
      use_fixed = 1; fixed_rd = 16'h00A7; model_lat = 20;
      bus.req_ss[2:0] = 3'b100;
      bus.req_data[15:0] = 16'h0905;
      bus.req[0] = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.wrt_SPI, bus.busy, bus.gnt} !== 5'b11001)
         $display("FAIL single_latency: got wrt=%b busy=%b gnt=%b, required 1 1 001", bus.wrt_SPI, bus.busy, bus.gnt);
      else passed++;
      wait_done(0, 1, 60, ok);
      total++;
      if (!ok) $display("FAIL single_wait: got ndone=%0d, required 1", ndone); else passed++;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok;
      int base;
      rst = 1'b1;
      @(negedge clk);
      use_fixed = 0; model_lat = 1;
      bus.req_ss = {3'd3, 3'd2, 3'd1};
      bus.req_data = {16'hC003, 16'hB002, 16'hA001};
      exp_q.push_back('{0, 3'd1, 16'hA001, 16'hA001 ^ 16'h5A5A, 1'b0});
      exp_q.push_back('{1, 3'd2, 16'hB002, 16'hB002 ^ 16'h5A5A, 1'b0});
      exp_q.push_back('{2, 3'd3, 16'hC003, 16'hC003 ^ 16'h5A5A, 1'b0});
      bus.req = 3'b111;
      wrt_cyc.delete();
      base = ndone;
      @(negedge clk);
      rst = 1'b0;
      wait_done(0, base + 3, 80, ok);
      total++;
      if (!ok) $display("FAIL rr_wait: got %0d dones, required 3", ndone - base); else passed++;
      total++;
      if (wrt_cyc.size() != 3) $display("FAIL rr_issues: got %0d issues, required 3", wrt_cyc.size());
      else if (wrt_cyc[1] - wrt_cyc[0] != 6 || wrt_cyc[2] - wrt_cyc[1] != 6)
         $display("FAIL rr_spacing: got %0d,%0d cycles, required 6,6", wrt_cyc[1] - wrt_cyc[0], wrt_cyc[2] - wrt_cyc[1]);
      else passed++;
      repeat (20) @(negedge clk);
      total++;
      if (ndone - base != 3) $display("FAIL rr_count: got %0d dones, required 3", ndone - base); else passed++;
   endtask

   task automatic test_fairness();
      bit ok;
      int base;
      base = ndone;
      bus.req_data[31:16] = 16'h1111;
      bus.req_ss[5:3] = 3'd5;
      exp_q.push_back('{1, 3'd5, 16'h1111, 16'h1111 ^ 16'h5A5A, 1'b0});
      bus.req = 3'b010;
      wait_done(0, base + 1, 40, ok);
      exp_q.push_back('{2, 3'd6, 16'h2222, 16'h2222 ^ 16'h5A5A, 1'b0});
      exp_q.push_back('{0, 3'd7, 16'h3333, 16'h3333 ^ 16'h5A5A, 1'b0});
      bus.req_ss = {3'd6, 3'd5, 3'd7};
      bus.req_data = {16'h2222, 16'h1111, 16'h3333};
      @(negedge clk);
      bus.req = 3'b101;
      wait_done(0, base + 3, 60, ok);
      total++;
      if (!ok) $display("FAIL fair_wait: got %0d dones, required 3", ndone - base); else passed++;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      bit ok;
      bit seen;
      int base;
      use_fixed = 1; fixed_rd = 16'h1357; model_lat = 30;
      bus.req_ss[5:3] = 3'd2;
      bus.req_data[31:16] = 16'h2468;
      exp_q.push_back('{1, 3'd2, 16'h2468, 16'h1357, 1'b0});
      bus.req = 3'b010;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.wrt_SPI) seen = 1;
      end
      repeat (3) @(negedge clk);
      base = ndone;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.gnt, bus.busy, bus.wrt_SPI, bus.done} !== 8'h00)
         $display("FAIL rst_mid: got gnt=%b busy=%b wrt=%b done=%b, required 0", bus.gnt, bus.busy, bus.wrt_SPI, bus.done);
      else passed++;
      exp_q.delete();
      exp_q.push_back('{1, 3'd2, 16'h2468, 16'h1357, 1'b0});
      model_lat = 3;
      repeat (2) @(negedge clk);
      total++;
      if (ndone != base) $display("FAIL rst_no_done: got %0d dones, required 0", ndone - base); else passed++;
      rst = 1'b0;
      wait_done(0, base + 1, 40, ok);
      total++;
      if (!ok) $display("FAIL rst_recover: got %0d dones, required 1", ndone - base); else passed++;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      int base;
      bus2.req_ss[2:0] = 3'd5;
      bus2.req_data[15:0] = 16'h1234;
      exp2_q.push_back('{0, 3'd5, 16'h1234, 16'h0000, 1'b1});
      bus2.req = 3'b001;
      wait_done(1, 1, 60, ok);
      total++;
      if (!ok) $display("FAIL to_wait: got ndone2=%0d, required 1", ndone2);
      else if (done2_cyc - wrt2_cyc != 17) $display("FAIL to_latency: got %0d cycles, required 17", done2_cyc - wrt2_cyc);
      else passed++;
      base = ndone2;
      repeat (4) @(negedge clk);
      bus2.SPI_rdata = 16'hFFFF;
      bus2.SPI_done = 1'b1;
      @(negedge clk);
      bus2.SPI_done = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (ndone2 != base || bus2.busy !== 1'b0 || bus2.gnt !== 3'b000)
         $display("FAIL late_done: got dones=%0d busy=%b gnt=%b, required 0 0 000", ndone2 - base, bus2.busy, bus2.gnt);
      else passed++;
   endtask

   task automatic test_coincident();
      bit ok;
      bit seen;
      bus2.req_ss[5:3] = 3'd6;
      bus2.req_data[31:16] = 16'h4321;
      exp2_q.push_back('{1, 3'd6, 16'h4321, 16'hBEEF, 1'b0});
      bus2.req = 3'b010;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus2.wrt_SPI) seen = 1;
      end
      repeat (16) @(negedge clk);
      bus2.SPI_rdata = 16'hBEEF;
      bus2.SPI_done = 1'b1;
      @(negedge clk);
      bus2.SPI_done = 1'b0;
      wait_done(1, 2, 20, ok);
      total++;
      if (!ok) $display("FAIL coinc_wait: got ndone2=%0d, required 2", ndone2);
      else if (done2_cyc - wrt2_cyc != 17) $display("FAIL coinc_latency: got %0d cycles, required 17", done2_cyc - wrt2_cyc);
      else passed++;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      rst_to = 1'b1;
      bus.req = '0; bus.req_ss = '0; bus.req_data = '0;
      bus.SPI_done = 1'b0; bus.SPI_rdata = '0;
      bus2.req = '0; bus2.req_ss = '0; bus2.req_data = '0;
      bus2.SPI_done = 1'b0; bus2.SPI_rdata = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_reset_mid_busy();
      test_timeout();
      test_coincident();
      total++;
      if (exp_q.size() != 0 || exp2_q.size() != 0)
         $display("FAIL leftover: got %0d/%0d pending responses, required 0/0", exp_q.size(), exp2_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
